cskipa_seq_ctrl: RTL

Multi-cycle sequencer that performs an OP_WIDTH-bit addition by time-multiplexing one CHUNK-bit carry-skip adder slice over OP_WIDTH/CHUNK cycles. The carry between chunks is registered. Operands enter, and results leave, through valid/ready handshakes. It sits between an operand source (e.g. a register file or DMA front end) and a result consumer, and trades latency for area against a full-width carry-skip adder.

---
 rtl/cskipa_pkg.sv | 17 +
 rtl/cskipa_seq_ctrl_if.sv | 25 ++
 rtl/cskipa_chunk_add.sv | 42 ++++
 rtl/cskipa_seq_ctrl.sv | 106 ++++++++++
 4 files changed

// File: rtl/cskipa_pkg.sv
// Shared types and constants for the time-multiplexed carry-skip adder sequencer.
package cskipa_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CHUNK_DEF = 12;
  localparam int SKIP_W    = 4;

  function automatic int idx_w(input int nchunk);
    return (nchunk <= 2) ? 1 : $clog2(nchunk);
  endfunction

endpackage

// File: rtl/cskipa_seq_ctrl_if.sv
// Operand/result handshake bundle between source, sequencer and consumer.
interface cskipa_seq_ctrl_if #(
  parameter int OP_WIDTH = 48
);
  logic                i_valid;
  logic                o_ready;
  logic [OP_WIDTH-1:0] i_add_term1;
  logic [OP_WIDTH-1:0] i_add_term2;
  logic                i_cin;
  logic                i_clear;
  logic                o_valid;
  logic                i_ready;
  logic [OP_WIDTH-1:0] o_sum;
  logic                o_cout;

  modport master (
    output i_valid, i_add_term1, i_add_term2, i_cin, i_clear, i_ready,
    input  o_ready, o_valid, o_sum, o_cout
  );

  modport slave (
    input  i_valid, i_add_term1, i_add_term2, i_cin, i_clear, i_ready,
    output o_ready, o_valid, o_sum, o_cout
  );
endinterface

// File: rtl/cskipa_chunk_add.sv
// CHUNK-bit carry-skip adder: 4-bit ripple groups whose carry is bypassed
// when every bit of the group propagates.
module cskipa_chunk_add
  import cskipa_pkg::*;
#(
  parameter int CHUNK = CHUNK_DEF
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);
  localparam int NGRP = CHUNK / SKIP_W;

  logic grp_c;
  logic rip_c;
  logic grp_p;
  logic bit_p;

  always_comb begin
    sum   = '0;
    grp_c = cin;
    rip_c = 1'b0;
    grp_p = 1'b0;
    bit_p = 1'b0;
    for (int g = 0; g < NGRP; g++) begin
      rip_c = grp_c;
      grp_p = 1'b1;
      for (int i = 0; i < SKIP_W; i++) begin
        bit_p                = a[g*SKIP_W+i] ^ b[g*SKIP_W+i];
        sum[g*SKIP_W+i]      = bit_p ^ rip_c;
        rip_c                = (a[g*SKIP_W+i] & b[g*SKIP_W+i]) | (bit_p & rip_c);
        grp_p                = grp_p & bit_p;
      end
      // A fully propagating group hands its incoming carry straight on.
      grp_c = grp_p ? grp_c : rip_c;
    end
    cout = grp_c;
  end

endmodule

// File: rtl/cskipa_seq_ctrl.sv
// Multi-cycle OP_WIDTH-bit adder: one shared CHUNK-bit carry-skip slice,
// one chunk per cycle, registered inter-chunk carry, valid/ready on both sides.
module cskipa_seq_ctrl
  import cskipa_pkg::*;
#(
  parameter int OP_WIDTH = 48,
  parameter int CHUNK    = CHUNK_DEF
) (
  input logic              i_clk,
  input logic              i_rst_n,
  cskipa_seq_ctrl_if.slave bus
);
  localparam int NCHUNK = OP_WIDTH / CHUNK;
  localparam int IDX_W  = idx_w(NCHUNK);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCHUNK - 1);

  if (OP_WIDTH % CHUNK != 0) begin : g_bad_op_width
    $error("OP_WIDTH must be a multiple of CHUNK");
  end
  if (CHUNK % SKIP_W != 0) begin : g_bad_chunk
    $error("CHUNK must be a multiple of the skip group width");
  end
  if (NCHUNK < 2) begin : g_bad_nchunk
    $error("OP_WIDTH/CHUNK must be at least 2");
  end

  state_t              state_q, state_d;
  logic [OP_WIDTH-1:0] op_a_q, op_b_q;
  logic [OP_WIDTH-1:0] result_q;
  logic                carry_q;
  logic [IDX_W-1:0]    idx_q;
  logic                accept;
  logic                step;
  logic [CHUNK-1:0]    slice_sum;
  logic                slice_cout;

  cskipa_chunk_add #(.CHUNK(CHUNK)) u_slice (
    .a    (op_a_q[CHUNK-1:0]),
    .b    (op_b_q[CHUNK-1:0]),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // Clear wins over both the operand accept and the result handshake.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      IDLE: if (bus.i_valid) begin
        state_d = RUN;
        accept  = 1'b1;
      end
      RUN: begin
        step = 1'b1;
        if (idx_q == IDX_LAST) state_d = DONE;
      end
      DONE: if (bus.i_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.i_clear) begin
      state_d = IDLE;
      accept  = 1'b0;
      step    = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      if (bus.i_clear) begin
        idx_q <= '0;
      end else if (accept) begin
        idx_q   <= '0;
        carry_q <= bus.i_cin;
      end else if (step) begin
        result_q[int'(idx_q)*CHUNK +: CHUNK] <= slice_sum;
        carry_q <= slice_cout;
        if (idx_q != IDX_LAST) idx_q <= idx_q + 1'b1;
      end
    end
  end

  // Operand shift registers carry no reset; they are reloaded on every accept.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      op_a_q <= bus.i_add_term1;
      op_b_q <= bus.i_add_term2;
    end else if (step) begin
      op_a_q <= op_a_q >> CHUNK;
      op_b_q <= op_b_q >> CHUNK;
    end
  end

  assign bus.o_ready = (state_q == IDLE);
  assign bus.o_valid = (state_q == DONE);
  assign bus.o_sum   = result_q;
  assign bus.o_cout  = carry_q;

endmodule
